// File: rtl/sar_adc_seq_if.sv
// SAR sequencer request/analog-side bundle; master drives requests and the comparator,
// slave (the sequencer) drives DAC code, sample switch, mux select and results.
interface sar_adc_seq_if #(
    parameter int NBITS = 8,
    parameter int NCH   = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             ena;
    logic             start;
    logic             mode;
    logic [CHW-1:0]   ch_sel;
    logic             cmp_in;
    logic [NBITS-1:0] dac_code;
    logic             sample;
    logic [CHW-1:0]   mux_ch;
    logic             busy;
    logic             valid;
    logic [NBITS-1:0] result;
    logic [CHW-1:0]   result_ch;

    modport master (
        output ena, start, mode, ch_sel, cmp_in,
        input  dac_code, sample, mux_ch, busy, valid, result, result_ch
    );

    modport slave (
        input  ena, start, mode, ch_sel, cmp_in,
        output dac_code, sample, mux_ch, busy, valid, result, result_ch
    );
endinterface

// File: rtl/sar_adc_seq.sv
// SAR conversion sequencer: valid SAMPLE_CYC+3*NBITS+1 cycles after an accepted start.
// No backpressure: start is only sampled in IDLE, ena low aborts to IDLE without a result.
module sar_adc_seq #(
    parameter int NBITS      = 8,
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sar_adc_seq_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW  = $clog2(NBITS);
    localparam int SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    localparam logic [NBITS-1:0] MSB     = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [SCW-1:0]   SLAST   = SCW'(SAMPLE_CYC - 1);
    localparam logic [BW-1:0]    BTOP    = BW'(NBITS - 1);
    localparam logic [CHW:0]     NCH_W   = (CHW+1)'(NCH);
    localparam logic [CHW:0]     LAST_CH = (CHW+1)'(NCH - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t           state;
    logic             scan;
    logic [SCW-1:0]   scnt;
    logic [1:0]       phase;
    logic [BW-1:0]    bit_idx;
    logic             cmp_s1, cmp_s2;
    logic [NBITS-1:0] dac_code, result;
    logic             sample, busy, valid;
    logic [CHW-1:0]   mux_ch, result_ch;
    logic [NBITS-1:0] trial_bit, decided;

    // dac_code already carries the trial bit, so the decision only needs to clear it
    always_comb begin
        trial_bit = NBITS'(1) << bit_idx;
        decided   = cmp_s2 ? dac_code : (dac_code & ~trial_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scan      <= 1'b0;
            scnt      <= '0;
            phase     <= '0;
            bit_idx   <= '0;
            cmp_s1    <= 1'b0;
            cmp_s2    <= 1'b0;
            dac_code  <= '0;
            sample    <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            mux_ch    <= '0;
            result    <= '0;
            result_ch <= '0;
        end else begin
            cmp_s1 <= bus.cmp_in;
            cmp_s2 <= cmp_s1;
            valid  <= 1'b0;
            if (!bus.ena) begin
                state    <= IDLE;
                busy     <= 1'b0;
                sample   <= 1'b0;
                dac_code <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            scan     <= bus.mode;
                            mux_ch   <= bus.mode ? '0 :
                                        (({1'b0, bus.ch_sel} < NCH_W) ? bus.ch_sel : '0);
                            scnt     <= '0;
                            busy     <= 1'b1;
                            sample   <= 1'b1;
                            dac_code <= '0;
                            state    <= SAMPLE;
                        end
                    end
                    SAMPLE: begin
                        if (scnt == SLAST) begin
                            sample   <= 1'b0;
                            bit_idx  <= BTOP;
                            phase    <= '0;
                            dac_code <= MSB;
                            state    <= CONVERT;
                        end else begin
                            scnt <= scnt + SCW'(1);
                        end
                    end
                    CONVERT: begin
                        // phase 0 settles the DAC, phases 1-2 let the comparator through the synchroniser
                        if (phase != 2'd2) begin
                            phase <= phase + 2'd1;
                        end else begin
                            phase <= '0;
                            if (bit_idx == '0) begin
                                result    <= decided;
                                result_ch <= mux_ch;
                                valid     <= 1'b1;
                                dac_code  <= '0;
                                state     <= DONE;
                            end else begin
                                bit_idx  <= bit_idx - BW'(1);
                                dac_code <= decided | (trial_bit >> 1);
                            end
                        end
                    end
                    DONE: begin
                        if (scan && ({1'b0, mux_ch} < LAST_CH)) begin
                            mux_ch <= mux_ch + CHW'(1);
                            scnt   <= '0;
                            sample <= 1'b1;
                            state  <= SAMPLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dac_code  = dac_code;
    assign bus.sample    = sample;
    assign bus.mux_ch    = mux_ch;
    assign bus.busy      = busy;
    assign bus.valid     = valid;
    assign bus.result    = result;
    assign bus.result_ch = result_ch;
endmodule

// File: doc/sar_adc_seq.md
# sar_adc_seq

Parametrised SAR ADC conversion sequencer for the mixed-signal tile. It drives the analog capacitive DAC code, sample switch and input-mux select, and resolves the result one bit per trial from an asynchronous comparator output. It generalises the first-generation single-channel analog top to NBITS resolution, NCH multiplexed inputs and a single/scan mode. It sits between the user I/O logic and the analog macro on `ua[5:0]`.

## Interface
- `NBITS`, 8, conversion resolution (2..12)
- `NCH`, 4, number of analog input channels (1..8); `CHW = max(1,$clog2(NCH))`
- `SAMPLE_CYC`, 4, sample-phase length in cycles (>=1)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `ena`  in  1  block enable; low aborts and holds IDLE
- `start`  in  1  conversion request, level-sampled in IDLE
- `mode`  in  1  0 = single channel `ch_sel`; 1 = scan channels 0..NCH-1
- `ch_sel`  in  CHW  channel for single mode (values >= NCH treated as 0)
- `cmp_in`  in  1  comparator output, asynchronous; 1 means Vin >= Vdac
- `dac_code`  out  NBITS  trial code to the capacitive DAC
- `sample`  out  1  sample switch enable
- `mux_ch`  out  CHW  analog mux select
- `busy`  out  1  high in any state other than IDLE
- `valid`  out  1  one-cycle pulse, result available
- `result`  out  NBITS  last completed code, held until next `valid`
- `result_ch`  out  CHW  channel of `result`

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: `busy`=0, `sample`=0, `dac_code`=0. On `ena && start`, latch `mode`, set channel (`ch_sel` or 0 for scan), go SAMPLE.
- SAMPLE: `sample`=1, `dac_code`=0, `mux_ch`=channel, SAMPLE_CYC cycles, then CONVERT with bit index = NBITS-1, working code = 0.
- CONVERT: each bit takes 3 cycles (phase 0,1,2). Phase 0: `dac_code` = working | (1<<i). Decision at edge ending phase 2 uses 2-flop synchronised `cmp_in`: 1 keeps bit i, 0 clears it. After bit 0 go DONE.
- DONE (1 cycle): `valid`=1, `result` = final code, `result_ch` = channel. Single mode -> IDLE. Scan mode: if channel < NCH-1, increment channel, go SAMPLE; else IDLE.
- `start` while busy ignored; `mode`/`ch_sel` changes while busy ignored.
- `ena` low in any state: next state IDLE, no `valid`, `result`/`result_ch` unchanged, synchroniser kept running.
- `mux_ch` holds the active channel through CONVERT and DONE; in IDLE holds last value.
- Comparator synchroniser is two flops, reset to 0; not reset by `ena`.

## Timing
- Reset values: `dac_code`=0, `sample`=0, `mux_ch`=0, `busy`=0, `valid`=0, `result`=0, `result_ch`=0, state IDLE, synchroniser 0.
- `start` high at edge T (IDLE): `busy`,`sample` high from T+1 to T+SAMPLE_CYC.
- CONVERT occupies T+SAMPLE_CYC+1 .. T+SAMPLE_CYC+3·NBITS; `valid` high in cycle T+SAMPLE_CYC+3·NBITS+1 (defaults: 29 cycles after T).
- Decision for a bit reflects `cmp_in` at the edge ending phase 0; DAC has one full cycle to settle before that edge.
- Scan: consecutive `valid` pulses spaced SAMPLE_CYC+3·NBITS+1 cycles (29 default); SAMPLE of next channel starts cycle after DONE.
- `busy` falls the cycle after the final DONE; a new `start` can be taken in that first IDLE cycle.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Single, ch_sel=2, model cmp=(0xA5 >= dac_code): `valid` 29 cycles after start, `result`=0xA5, `result_ch`=2, `dac_code` trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- Extremes: vin 0x00 -> result 0x00; vin 0xFF -> 0xFF; vin 0x80 -> 0x80.
- Scan mode, channels 0..3 with vin 0x10,0x80,0xC3,0x7F: four `valid` pulses 29 cycles apart, result_ch 0,1,2,3, results equal; `busy` low after the fourth.
- Abort: `ena` dropped during CONVERT bit 4 -> `busy`=0 next cycle, no `valid`, `result` keeps previous 0xA5; subsequent start converts normally.
- `start` and `ch_sel` toggled while busy -> ignored, one `valid` only, original channel reported.
- `rst_n` asserted mid-SAMPLE and mid-CONVERT: all outputs return to reset values immediately (async), restart after release gives correct result.
